serial_adder_ctrl: RTL and testbench

//  Bit-serial N-bit adder controller built around one full_adder instance (a,b,c -> sum,carry).

---
 rtl/serial_adder_ctrl.sv | 176 +++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, start/busy/done handshake.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic               carry_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               accept_s;
    logic               run_s;
    logic               last_s;
    logic               fa_sum_s;
    logic               fa_carry_s;
    logic [WIDTH-1:0]   res_nxt_s;

    full_adder u_fa (
        .a     (a_sh_r[0]),
        .b     (b_sh_r[0]),
        .c     (carry_r),
        .sum   (fa_sum_s),
        .carry (fa_carry_s)
    );

    // Handshake decode and next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        run_s       = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                accept_s = start;
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                run_s  = 1'b1;
                last_s = (cnt_r == CNT_LAST);
                if (cnt_r == CNT_LAST) state_nxt_s = ST_DONE;
                else                   state_nxt_s = ST_RUN;
            end
            ST_DONE: begin
                accept_s = start;
                if (start) state_nxt_s = ST_RUN;
                else       state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Operand shift registers, carry flip-flop and bit counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (accept_s) begin
            a_sh_r  <= op_a;
            b_sh_r  <= op_b;
            carry_r <= cin;
            cnt_r   <= {CW{1'b0}};
        end else if (run_s) begin
            a_sh_r  <= a_sh_r >> 1;
            b_sh_r  <= b_sh_r >> 1;
            carry_r <= fa_carry_s;
            cnt_r   <= cnt_r + CNT_ONE;
        end else begin
            a_sh_r  <= a_sh_r;
            b_sh_r  <= b_sh_r;
            carry_r <= carry_r;
            cnt_r   <= cnt_r;
        end
    end

    // Only result bits [WIDTH-1:1] are stored; bit 0 is always overwritten before use.
    if (WIDTH == 1) begin : g_res_w1
        assign res_nxt_s = fa_sum_s;
    end else begin : g_res_wn
        logic [WIDTH-2:0] res_sh_r;

        // Result shift register, filled MSB-first as sum bits arrive LSB-first.
        always_ff @(posedge clk) begin
            if (!rst_n)        res_sh_r <= {(WIDTH-1){1'b0}};
            else if (accept_s) res_sh_r <= {(WIDTH-1){1'b0}};
            else if (run_s)    res_sh_r <= res_nxt_s[WIDTH-1:1];
            else               res_sh_r <= res_sh_r;
        end

        assign res_nxt_s = {fa_sum_s, res_sh_r};
    end

    // Result registers, updated only when the final bit is produced.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
        end else if (last_s) begin
            sum_r  <= res_nxt_s;
            cout_r <= fa_carry_s;
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_r;

    // Overflow: carry into the MSB (carry_r on the last bit) versus carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n)      ovf_r <= 1'b0;
        else if (last_s) ovf_r <= carry_r ^ fa_carry_s;
        else             ovf_r <= ovf_r;
    end

    assign ovf = ovf_r;
`else
`endif

    assign busy = (state_r == ST_RUN);
    assign done = (state_r == ST_DONE);
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed handshake cases plus a random sweep
// against an arithmetic reference model. Define SERIAL_ADD_OVF_EN to also check ovf.
module tb_serial_adder_ctrl;
    parameter int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_full(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c);
        ref_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Signed overflow: equal operand signs but a result sign that differs from them.
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c);
        logic [W:0] f;
        f = ref_full(a, b, c);
        ref_ovf = (a[W-1] == b[W-1]) && (f[W-1] != a[W-1]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c);
        logic [W:0] f;
        f = ref_full(a, b, c);
        check_val({tag, "_sum"}, 64'(sum), 64'(f[W-1:0]));
        check_val({tag, "_cout"}, 64'(cout), 64'(f[W]));
`ifdef SERIAL_ADD_OVF_EN
        check_val({tag, "_ovf"}, 64'(ovf), 64'(ref_ovf(a, b, c)));
`endif
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_sum"},  64'(sum),  64'd0);
        check_val({tag, "_cout"}, 64'(cout), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        check_val({tag, "_ovf"},  64'(ovf),  64'd0);
`endif
    endtask

    // Issue one add from the current cycle; returns positioned on the DONE cycle.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit chk_busy, input string tag);
        start = 1'b1; op_a = a; op_b = b; cin = c;
        step();
        start = 1'b0; op_a = W'($urandom()); op_b = W'($urandom()); cin = 1'($urandom());
        for (int k = 1; k <= W; k++) begin
            if (chk_busy) begin
                check_val({tag, "_busy"}, 64'(busy), 64'd1);
                check_val({tag, "_nodone"}, 64'(done), 64'd0);
            end
            step();
        end
        check_val({tag, "_done"}, 64'(done), 64'd1);
        check_val({tag, "_busy_lo"}, 64'(busy), 64'd0);
        check_result(tag, a, b, c);
    endtask

    logic [W-1:0] va, vb, xa, xb;
    logic [63:0]  rnd;
    int           dones;
    int           pk;

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b1; op_a = '1; op_b = '1; cin = 1'b1;
        step(); step(); step();
        check_cleared("reset");
        rst_n = 1'b1; start = 1'b0;
        step();
        check_cleared("idle");

        // Basic add with full busy/done timing.
        va = W'(64'h3C); vb = W'(64'h0F);
        do_add(va, vb, 1'b0, 1'b1, "t1");
        step();
        check_val("t1_pulse", 64'(done), 64'd0);
        check_result("t1_hold", va, vb, 1'b0);

        // Wrap-around and signed-overflow boundaries.
        va = {W{1'b1}}; vb = W'(64'h1);
        do_add(va, vb, 1'b0, 1'b0, "t2a");
        step();
        va = {W{1'b1}} >> 1; vb = {W{1'b0}};
        do_add(va, vb, 1'b1, 1'b0, "t2b");
        step();

        // Start asserted mid-run is ignored.
        va = W'(64'h21); vb = W'(64'h13);
        xa = W'(64'hC4); xb = W'(64'h7E);
        pk = (W < 4) ? W : 4;
        start = 1'b1; op_a = va; op_b = vb; cin = 1'b1;
        step();
        dones = 0;
        for (int k = 1; k <= W + 3; k++) begin
            start = (k == pk);
            op_a  = xa; op_b = xb; cin = 1'b0;
            if (done) dones++;
            step();
        end
        start = 1'b0;
        check_val("t3_dones", 64'(dones), 64'd1);
        check_result("t3", va, vb, 1'b1);

        // Reset mid-run aborts the add.
        pk = (W < 5) ? W : 5;
        start = 1'b1; op_a = W'(64'h5A); op_b = W'(64'h66); cin = 1'b0;
        step();
        start = 1'b0;
        for (int k = 1; k < pk; k++) step();
        rst_n = 1'b0;
        step();
        check_cleared("t4_rst");
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < W + 3; k++) begin
            if (done) dones++;
            step();
        end
        check_val("t4_nodone", 64'(dones), 64'd0);
        va = W'(64'h9D); vb = W'(64'h31);
        do_add(va, vb, 1'b1, 1'b1, "t4_after");
        step();

        // Back-to-back with start held across DONE.
        start = 1'b1; op_a = W'(64'h10); op_b = W'(64'h20); cin = 1'b0;
        step();
        op_a = W'(64'hAA); op_b = W'(64'h55); cin = 1'b1;
        check_val("t5_busy1", 64'(busy), 64'd1);
        for (int k = 1; k <= W; k++) step();
        check_val("t5_done1", 64'(done), 64'd1);
        check_result("t5a", W'(64'h10), W'(64'h20), 1'b0);
        step();
        start = 1'b0;
        check_val("t5_busy2", 64'(busy), 64'd1);
        check_val("t5_nodone", 64'(done), 64'd0);
        for (int k = 1; k <= W; k++) step();
        check_val("t5_done2", 64'(done), 64'd1);
        check_result("t5b", W'(64'hAA), W'(64'h55), 1'b1);

        // Random sweep, mixing back-to-back and idle gaps.
        for (int n = 0; n < 1000; n++) begin
            rnd = {$urandom(), $urandom()};
            va  = rnd[W-1:0];
            rnd = {$urandom(), $urandom()};
            vb  = rnd[W-1:0];
            do_add(va, vb, 1'($urandom()), 1'b0, "rand");
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
